// File: rtl/seq_to_sim_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_to_sim_load_ctrl_pkg
//   Definitions shared by the shift-register sequencing controllers of the BCH
//   decoder front end:
//     - 2-bit state encodings CLR/FILL/PAD/FULL (legacy-compatible constants)
//     - bitWidthCal(n)  : bits needed to hold the values 0..n (minimum 1)
//     - notBeingZero(n) : 1 when n is non-zero
// -----------------------------------------------------------------------------
package seq_to_sim_load_ctrl_pkg;

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    function automatic int bitWidthCal(input int value);
        int w;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((value >> i) != 0) w = int'(i) + 1;
        end
        return w;
    endfunction

    function automatic bit notBeingZero(input int value);
        return value != 0;
    endfunction

endpackage

// File: rtl/seq_to_sim_load_ctrl_fill_len.sv
// -----------------------------------------------------------------------------
// fill_len_counter
//   Counts the words shifted into the current frame.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset, clears the count
//     clr    : synchronous clear to 0 (highest priority)
//     inc    : increment by one
//     sat    : load SHIFT_LEN (frame complete; saturated display)
//     count  : current count
//     tc     : count == SHIFT_LEN-1 (next shift completes the frame)
// -----------------------------------------------------------------------------
module fill_len_counter
    import seq_to_sim_load_ctrl_pkg::*;
#(
    parameter int SHIFT_LEN = 8,
    parameter int CNT_W     = bitWidthCal(SHIFT_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             sat,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sat) begin
            count <= CNT_W'(SHIFT_LEN);
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(SHIFT_LEN - 1));

endmodule

// File: rtl/seq_to_sim_load_ctrl.sv
// -----------------------------------------------------------------------------
// seq_to_sim_load_ctrl
//   Sequencing controller for the sequential-to-simultaneous shift register.
//   Accepts SHIFT_LEN words over a valid/ready handshake, drives the shift
//   register clear/enable/shift-enable, then presents the parallel frame to the
//   syndrome stage and holds it until accepted.
//   Optional feature (macro SEQ_TO_SIM_LOAD_CTRL_PAD_EN): a word flagged with
//   in_last before the frame is full triggers zero-padding of the remainder.
//   Ports:
//     clk            : clock, rising edge
//     in_ctr_Arst_n  : asynchronous active-low reset
//     in_ctr_flush   : synchronous abort of the partial or held frame
//     in_valid       : upstream word valid
//     in_last        : last word of a short frame (pad feature only)
//     in_ready       : controller accepts a word this cycle
//     out_ctr_Srst   : shift-register synchronous clear
//     out_ctr_en     : shift-register enable
//     out_ctr_sh_en  : shift-register shift-enable
//     out_pad        : select zero into the shift-register input
//     out_valid      : parallel frame complete
//     out_ready      : syndrome stage accepts the frame
//     out_fill_cnt   : words shifted into the current frame
//     out_frame_cnt  : frames handed off (wrapping)
// -----------------------------------------------------------------------------
module seq_to_sim_load_ctrl
    import seq_to_sim_load_ctrl_pkg::*;
#(
    parameter  int SHIFT_LEN   = 8,
    parameter  int FRAME_CNT_W = 8,
    localparam int CNT_W       = bitWidthCal(SHIFT_LEN)
) (
    input  logic                   clk,
    input  logic                   in_ctr_Arst_n,
    input  logic                   in_ctr_flush,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_ctr_Srst,
    output logic                   out_ctr_en,
    output logic                   out_ctr_sh_en,
    output logic                   out_pad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_fill_cnt,
    output logic [FRAME_CNT_W-1:0] out_frame_cnt
);

    if (!notBeingZero(SHIFT_LEN) || SHIFT_LEN < 0) begin : g_bad_shift_len
        $error("seq_to_sim_load_ctrl: SHIFT_LEN must be >= 1");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       fill_clr;
    logic       fill_inc;
    logic       fill_sat;
    logic       fill_tc;
    logic       handoff;

`ifndef SEQ_TO_SIM_LOAD_CTRL_PAD_EN
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    fill_len_counter #(
        .SHIFT_LEN (SHIFT_LEN),
        .CNT_W     (CNT_W)
    ) u_fill_len_counter (
        .clk   (clk),
        .rst_n (in_ctr_Arst_n),
        .clr   (fill_clr),
        .inc   (fill_inc),
        .sat   (fill_sat),
        .count (out_fill_cnt),
        .tc    (fill_tc)
    );

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        out_ctr_Srst  = 1'b0;
        out_ctr_en    = 1'b0;
        out_ctr_sh_en = 1'b0;
        out_pad       = 1'b0;
        out_valid     = 1'b0;
        fill_clr      = 1'b0;
        fill_inc      = 1'b0;
        fill_sat      = 1'b0;
        handoff       = 1'b0;

        case (state)
            ST_CLR: begin
                out_ctr_Srst = 1'b1;
                out_ctr_en   = 1'b1;
                fill_clr     = 1'b1;
                state_nxt    = ST_FILL;
            end

            ST_FILL: begin
                // Flush blocks the handshake so the word offered this cycle is
                // not consumed; the count is cleared right away.
                if (in_ctr_flush) begin
                    fill_clr  = 1'b1;
                    state_nxt = ST_CLR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        out_ctr_sh_en = 1'b1;
                        out_ctr_en    = 1'b1;
                        if (fill_tc) begin
                            fill_sat  = 1'b1;
                            state_nxt = ST_FULL;
                        end else begin
                            fill_inc = 1'b1;
`ifdef SEQ_TO_SIM_LOAD_CTRL_PAD_EN
                            if (in_last) state_nxt = ST_PAD;
`endif
                        end
                    end
                end
            end

`ifdef SEQ_TO_SIM_LOAD_CTRL_PAD_EN
            ST_PAD: begin
                if (in_ctr_flush) begin
                    fill_clr  = 1'b1;
                    state_nxt = ST_CLR;
                end else begin
                    out_pad       = 1'b1;
                    out_ctr_sh_en = 1'b1;
                    out_ctr_en    = 1'b1;
                    if (fill_tc) begin
                        fill_sat  = 1'b1;
                        state_nxt = ST_FULL;
                    end else begin
                        fill_inc = 1'b1;
                    end
                end
            end
`endif

            ST_FULL: begin
                out_valid = 1'b1;
                // A handoff in the same cycle as a flush still counts.
                if (out_ready) begin
                    handoff   = 1'b1;
                    state_nxt = ST_CLR;
                end else if (in_ctr_flush) begin
                    state_nxt = ST_CLR;
                end
            end

            default: begin
                state_nxt = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state         <= ST_CLR;
            out_frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (handoff) out_frame_cnt <= out_frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_to_sim_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_to_sim_load_ctrl
//   Directed bench: main instance SHIFT_LEN=4, FRAME_CNT_W=2; second instance
//   SHIFT_LEN=1 for the single-word frame case. Each vector row describes one
//   clock cycle: inputs held during the cycle and the outputs expected then.
// -----------------------------------------------------------------------------
module tb_seq_to_sim_load_ctrl;

`ifdef SEQ_TO_SIM_LOAD_CTRL_PAD_EN
    localparam bit PADV = 1'b1;
`else
    localparam bit PADV = 1'b0;
`endif

    typedef struct {
        bit flush;
        bit valid;
        bit last;
        bit oready;
        bit rdy;
        bit srst;
        bit en;
        bit sh;
        bit pad;
        bit ov;
        int fill;
        int frame;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       valid;
    logic       last;
    logic       oready;
    logic       rdy;
    logic       srst;
    logic       en;
    logic       sh;
    logic       pad;
    logic       ov;
    logic [2:0] fill;
    logic [1:0] frame;

    logic       u1_flush;
    logic       u1_valid;
    logic       u1_last;
    logic       u1_oready;
    logic       u1_rdy;
    logic       u1_srst;
    logic       u1_en;
    logic       u1_sh;
    logic       u1_pad;
    logic       u1_ov;
    logic [0:0] u1_fill;
    logic [7:0] u1_frame;

    int n_chk;
    int n_fail;
    vec_t vecs[$];

    seq_to_sim_load_ctrl #(
        .SHIFT_LEN   (4),
        .FRAME_CNT_W (2)
    ) u_dut (
        .clk           (clk),
        .in_ctr_Arst_n (rst_n),
        .in_ctr_flush  (flush),
        .in_valid      (valid),
        .in_last       (last),
        .in_ready      (rdy),
        .out_ctr_Srst  (srst),
        .out_ctr_en    (en),
        .out_ctr_sh_en (sh),
        .out_pad       (pad),
        .out_valid     (ov),
        .out_ready     (oready),
        .out_fill_cnt  (fill),
        .out_frame_cnt (frame)
    );

    seq_to_sim_load_ctrl #(
        .SHIFT_LEN   (1),
        .FRAME_CNT_W (8)
    ) u_dut1 (
        .clk           (clk),
        .in_ctr_Arst_n (rst_n),
        .in_ctr_flush  (u1_flush),
        .in_valid      (u1_valid),
        .in_last       (u1_last),
        .in_ready      (u1_rdy),
        .out_ctr_Srst  (u1_srst),
        .out_ctr_en    (u1_en),
        .out_ctr_sh_en (u1_sh),
        .out_pad       (u1_pad),
        .out_valid     (u1_ov),
        .out_ready     (u1_oready),
        .out_fill_cnt  (u1_fill),
        .out_frame_cnt (u1_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input bit fl, input bit va, input bit la, input bit orr,
                                input bit r, input bit s, input bit e, input bit h,
                                input bit p, input bit o, input int f, input int fr);
        vec_t v;
        v.flush = fl; v.valid = va; v.last = la; v.oready = orr;
        v.rdy = r; v.srst = s; v.en = e; v.sh = h; v.pad = p; v.ov = o;
        v.fill = f; v.frame = fr;
        return v;
    endfunction

    // Row for a cycle in FILL where the offered word is accepted.
    function automatic vec_t acc(input int f, input int fr);
        return mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, f, fr);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs set just after the edge, outputs checked 1ns
    // later, then advance to 1ns past the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        flush  = v.flush;
        valid  = v.valid;
        last   = v.last;
        oready = v.oready;
        #1;
        chk({tag, ".in_ready"},      int'(rdy),   int'(v.rdy));
        chk({tag, ".srst"},          int'(srst),  int'(v.srst));
        chk({tag, ".en"},            int'(en),    int'(v.en));
        chk({tag, ".sh_en"},         int'(sh),    int'(v.sh));
        chk({tag, ".pad"},           int'(pad),   int'(v.pad));
        chk({tag, ".out_valid"},     int'(ov),    int'(v.ov));
        chk({tag, ".fill_cnt"},      int'(fill),  v.fill);
        chk({tag, ".frame_cnt"},     int'(frame), v.frame);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        valid     = 1'b1;
        last      = 1'b0;
        oready    = 1'b0;
        u1_flush  = 1'b0;
        u1_valid  = 1'b0;
        u1_last   = 1'b0;
        u1_oready = 1'b0;

        // fl va la or | rdy srst en sh pad ov fill frame
        // Basic frame with immediate handoff
        vecs.push_back(mk(0,1,0,0, 0,1,1,0,0,0, 0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(acc(k, 0));
        vecs.push_back(mk(0,1,0,1, 0,0,0,0,0,1, 4,0));
        vecs.push_back(mk(0,1,0,0, 0,1,1,0,0,0, 4,1));
        // Backpressure: 10 cycles held in FULL, then handoff and 2-cycle gap
        for (int k = 0; k < 4; k++) vecs.push_back(acc(k, 1));
        for (int k = 0; k < 10; k++) vecs.push_back(mk(0,1,0,0, 0,0,0,0,0,1, 4,1));
        vecs.push_back(mk(0,1,0,1, 0,0,0,0,0,1, 4,1));
        vecs.push_back(mk(0,1,0,0, 0,1,1,0,0,0, 4,2));
        // Flush after 2 words with a word on offer
        vecs.push_back(acc(0, 2));
        vecs.push_back(acc(1, 2));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0,0, 2,2));
        vecs.push_back(mk(0,0,0,0, 0,1,1,0,0,0, 0,2));
        vecs.push_back(mk(0,0,0,0, 1,0,0,0,0,0, 0,2));
        // Flush together with out_ready in FULL: counted
        for (int k = 0; k < 4; k++) vecs.push_back(acc(k, 2));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0,1, 4,2));
        vecs.push_back(mk(0,0,0,0, 0,1,1,0,0,0, 4,3));
        // Flush alone in FULL: dropped; flush in CLR: no effect
        for (int k = 0; k < 4; k++) vecs.push_back(acc(k, 3));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,1, 4,3));
        vecs.push_back(mk(1,0,0,0, 0,1,1,0,0,0, 4,3));
        vecs.push_back(mk(0,0,0,0, 1,0,0,0,0,0, 0,3));
        // Fourth counted handoff wraps the 2-bit frame counter 3 -> 0
        for (int k = 0; k < 4; k++) vecs.push_back(acc(k, 3));
        vecs.push_back(mk(0,0,0,1, 0,0,0,0,0,1, 4,3));
        vecs.push_back(mk(0,0,0,0, 0,1,1,0,0,0, 4,0));
        // in_last on word 2 of 4: padding with the feature, ignored without
        vecs.push_back(acc(0, 0));
        vecs.push_back(mk(0,1,1,0, 1,0,1,1,0,0, 1,0));
        vecs.push_back(mk(0,1,0,0, !PADV,0,1,1,PADV,0, 2,0));
        vecs.push_back(mk(0,1,0,0, !PADV,0,1,1,PADV,0, 3,0));
        vecs.push_back(mk(0,1,0,1, 0,0,0,0,0,1, 4,0));
        vecs.push_back(mk(0,0,0,0, 0,1,1,0,0,0, 4,1));

        // Reset state, checked mid-cycle while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("reset.srst",      int'(srst),  1);
        chk("reset.en",        int'(en),    1);
        chk("reset.in_ready",  int'(rdy),   0);
        chk("reset.out_valid", int'(ov),    0);
        chk("reset.sh_en",     int'(sh),    0);
        chk("reset.pad",       int'(pad),   0);
        chk("reset.fill_cnt",  int'(fill),  0);
        chk("reset.frame_cnt", int'(frame), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Two more frames bring frame_cnt to 3
        for (int fr = 1; fr <= 2; fr++) begin
            for (int k = 0; k < 4; k++) apply(acc(k, fr), $sformatf("seq_f%0d_w%0d", fr, k));
            apply(mk(0,0,0,1, 0,0,0,0,0,1, 4,fr),   $sformatf("seq_f%0d_full", fr));
            apply(mk(0,0,0,0, 0,1,1,0,0,0, 4,fr+1), $sformatf("seq_f%0d_clr", fr));
        end
        for (int k = 0; k < 3; k++) apply(acc(k, 3), $sformatf("seq_pre_rst_w%0d", k));
        apply(mk(0,0,0,0, 1,0,0,0,0,0, 3,3), "seq_pre_rst_idle");

        // Asynchronous reset mid-FILL with fill_cnt=3 and frame_cnt=3
        rst_n = 1'b0;
        #1;
        chk("arst.fill_cnt",  int'(fill),  0);
        chk("arst.frame_cnt", int'(frame), 0);
        chk("arst.srst",      int'(srst),  1);
        chk("arst.en",        int'(en),    1);
        chk("arst.in_ready",  int'(rdy),   0);
        chk("arst.out_valid", int'(ov),    0);
        #1;
        rst_n = 1'b1;

        // SHIFT_LEN=1 instance: one accept goes straight to FULL
        u1_valid = 1'b1;
        #1;
        chk("len1.clr.srst",     int'(u1_srst), 1);
        chk("len1.clr.in_ready", int'(u1_rdy),  0);
        @(posedge clk);
        #1;
        chk("len1.fill.in_ready", int'(u1_rdy),  1);
        chk("len1.fill.sh_en",    int'(u1_sh),   1);
        chk("len1.fill.fill_cnt", int'(u1_fill), 0);
        @(posedge clk);
        #1;
        u1_valid  = 1'b0;
        u1_oready = 1'b1;
        #1;
        chk("len1.full.out_valid", int'(u1_ov),    1);
        chk("len1.full.sh_en",     int'(u1_sh),    0);
        chk("len1.full.fill_cnt",  int'(u1_fill),  1);
        chk("len1.full.frame_cnt", int'(u1_frame), 0);
        chk("len1.full.pad",       int'(u1_pad),   0);
        @(posedge clk);
        #1;
        u1_oready = 1'b0;
        chk("len1.clr2.srst",      int'(u1_srst),  1);
        chk("len1.clr2.frame_cnt", int'(u1_frame), 1);
        chk("len1.clr2.en",        int'(u1_en),    1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
